// File: rtl/piso_arb_ctrl.sv
// Two-requester parallel-in/serial-out controller: round-robin arbitration
// between req0/req1, then MSB-first shifting of the granted word.
module piso_arb_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sout,
    output logic             sout_valid,
    output logic             owner,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             last_served_r;
    logic             owner_r;
    logic             gnt0_r;
    logic             gnt1_r;
    logic             done_r;
    logic             grant_s;
    logic             sel_s;
    logic             last_bit_s;

    // Arbitration: a lone request wins outright, a tie goes to the requester not served last.
    always_comb begin
        grant_s = 1'b0;
        sel_s   = 1'b0;
        if (req0 && req1) begin
            grant_s = 1'b1;
            sel_s   = ~last_served_r;
        end else if (req1) begin
            grant_s = 1'b1;
            sel_s   = 1'b1;
        end else if (req0) begin
            grant_s = 1'b1;
            sel_s   = 1'b0;
        end else begin
            grant_s = 1'b0;
            sel_s   = 1'b0;
        end
    end

    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: word capture, shifting, counters and the one-cycle gnt/done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r       <= '0;
            cnt_r         <= '0;
            owner_r       <= 1'b0;
            last_served_r <= 1'b1;
            gnt0_r        <= 1'b0;
            gnt1_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        shreg_r <= sel_s ? din1 : din0;
                        owner_r <= sel_s;
                        cnt_r   <= '0;
                        gnt0_r  <= ~sel_s;
                        gnt1_r  <= sel_s;
                    end
                end
                SHIFT: begin
                    shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                    if (last_bit_s) begin
                        cnt_r         <= '0;
                        done_r        <= 1'b1;
                        last_served_r <= owner_r;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign gnt0       = gnt0_r;
    assign gnt1       = gnt1_r;
    assign done       = done_r;
    assign owner      = owner_r;
    assign busy       = (state_r == SHIFT);
    assign sout_valid = (state_r == SHIFT);
    assign sout       = (state_r == SHIFT) ? shreg_r[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Directed self-checking bench for piso_arb_ctrl (WIDTH=4).
module tb_piso_arb_ctrl;

    logic       clk;
    logic       rst;
    logic       req0;
    logic [3:0] din0;
    logic       req1;
    logic [3:0] din1;
    logic       gnt0;
    logic       gnt1;
    logic       sout;
    logic       sout_valid;
    logic       owner;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    piso_arb_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .din0(din0), .req1(req1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .sout(sout), .sout_valid(sout_valid),
        .owner(owner), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req0 = 1'b1; din0 = 4'h9;
        tick();
        checks++;
        if ({gnt0, gnt1, sout, sout_valid, busy, done, owner} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000", {gnt0, gnt1, sout, sout_valid, busy, done, owner});
        end
        req0 = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if ({gnt0, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_grant: gnt0,busy got %b expected 00", {gnt0, busy});
        end
    endtask

    task automatic test_single;
        logic [3:0] w;
        w = 4'hC;
        req0 = 1'b1; din0 = w;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({gnt0, gnt1} !== ((i == 0) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL single_gnt[%0d]: got %b", i, {gnt0, gnt1});
            end
            checks++;
            if ({sout, sout_valid, busy, owner, done} !== {w[3-i], 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL single_bit[%0d]: sout,valid,busy,owner,done got %b expected %b",
                         i, {sout, sout_valid, busy, owner, done}, {w[3-i], 4'b1100});
            end
            tick();
        end
        checks++;
        if ({done, busy, sout_valid, sout, gnt0} !== 5'b10000) begin
            errors++;
            $display("FAIL single_done: done,busy,valid,sout,gnt0 got %b expected 10000", {done, busy, sout_valid, sout, gnt0});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_contention;
        logic [3:0] w;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1; din0 = 4'hF; din1 = 4'h5;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1, owner} !== 3'b100) begin
            errors++;
            $display("FAIL cont_first_gnt: gnt0,gnt1,owner got %b expected 100", {gnt0, gnt1, owner});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout, sout_valid} !== 2'b11) begin
                errors++;
                $display("FAIL cont_word0[%0d]: got %b expected 11", i, {sout, sout_valid});
            end
            tick();
        end
        checks++;
        if ({done, gnt0, gnt1} !== 3'b100) begin
            errors++;
            $display("FAIL cont_done0: done,gnt0,gnt1 got %b expected 100", {done, gnt0, gnt1});
        end
        tick();
        req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1, owner, done} !== 4'b0110) begin
            errors++;
            $display("FAIL cont_second_gnt: gnt0,gnt1,owner,done got %b expected 0110", {gnt0, gnt1, owner, done});
        end
        w = 4'h5;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout, sout_valid} !== {w[3-i], 1'b1}) begin
                errors++;
                $display("FAIL cont_word1[%0d]: got %b expected %b", i, {sout, sout_valid}, {w[3-i], 1'b1});
            end
            tick();
        end
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL cont_done1: done,busy got %b expected 10", {done, busy});
        end
    endtask

    task automatic test_fairness;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1; din0 = 4'hA; din1 = 4'h3;
        tick();
        for (int w = 0; w < 4; w++) begin
            checks++;
            if ({gnt0, gnt1, owner, sout} !== ((w % 2 == 0) ? 4'b1001 : 4'b0110)) begin
                errors++;
                $display("FAIL fair_gnt[%0d]: gnt0,gnt1,owner,sout got %b", w, {gnt0, gnt1, owner, sout});
            end
            repeat (4) tick();
            checks++;
            if ({done, gnt0, gnt1, busy} !== 4'b1000) begin
                errors++;
                $display("FAIL fair_done[%0d]: done,gnt0,gnt1,busy got %b expected 1000", w, {done, gnt0, gnt1, busy});
            end
            if (w == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
        end
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL fair_end: gnt0,gnt1,busy got %b expected 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_reset_mid_word;
        logic [3:0] w;
        apply_reset();
        req1 = 1'b1; din1 = 4'h7;
        tick();
        req1 = 1'b0;
        tick();
        checks++;
        if ({sout, busy, owner} !== 3'b111) begin
            errors++;
            $display("FAIL mid_second_bit: sout,busy,owner got %b expected 111", {sout, busy, owner});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({gnt0, gnt1, sout, sout_valid, busy, done, owner} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 0000000", {gnt0, gnt1, sout, sout_valid, busy, done, owner});
        end
        tick();
        checks++;
        if ({busy, gnt1, done} !== 3'b000) begin
            errors++;
            $display("FAIL mid_not_resent: busy,gnt1,done got %b expected 000", {busy, gnt1, done});
        end
        w = 4'h1;
        req0 = 1'b1; din0 = w;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL mid_regrant: gnt0,gnt1 got %b expected 10", {gnt0, gnt1});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout, sout_valid} !== {w[3-i], 1'b1}) begin
                errors++;
                $display("FAIL mid_word[%0d]: got %b expected %b", i, {sout, sout_valid}, {w[3-i], 1'b1});
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL mid_done: got %b expected 1", done);
        end
    endtask

    task automatic test_dropped_and_ignored;
        logic [3:0] w;
        apply_reset();
        req0 = 1'b1; din0 = 4'hB;
        #2;
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL drop_no_grant: gnt0,gnt1,busy got %b expected 000", {gnt0, gnt1, busy});
        end
        w = 4'h5;
        req1 = 1'b1; din1 = w;
        tick();
        req1 = 1'b0;
        checks++;
        if ({gnt1, owner} !== 2'b11) begin
            errors++;
            $display("FAIL ign_gnt: gnt1,owner got %b expected 11", {gnt1, owner});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout, sout_valid} !== {w[3-i], 1'b1}) begin
                errors++;
                $display("FAIL ign_word[%0d]: got %b expected %b", i, {sout, sout_valid}, {w[3-i], 1'b1});
            end
            din1 = ~din1;
            tick();
        end
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ign_done: done,busy got %b expected 10", {done, busy});
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = 4'h0; din1 = 4'h0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_reset_mid_word();
        test_dropped_and_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_arb_ctrl.md
PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: bits per parallel word; legal range 2..16.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 req0  input  1  requester 0 has a word pending; held high until gnt0.
REQ-005 din0  input  WIDTH  requester 0 parallel word; held stable while req0 is high.
REQ-006 req1  input  1  requester 1 has a word pending; held high until gnt1.
REQ-007 din1  input  WIDTH  requester 1 parallel word; held stable while req1 is high.
REQ-008 gnt0  output  1  registered one-cycle pulse: din0 accepted.
REQ-009 gnt1  output  1  registered one-cycle pulse: din1 accepted.
REQ-010 sout  output  1  serial data bit, MSB first.
REQ-011 sout_valid  output  1  high while sout carries a valid bit.
REQ-012 owner  output  1  index of the requester whose word is being shifted; holds its last value in IDLE.
REQ-013 busy  output  1  high in SHIFT state.
REQ-014 done  output  1  registered one-cycle pulse after the last bit of a word.

Function
REQ-015 FSM states: IDLE, SHIFT. Internal state: shift register shreg[WIDTH-1:0], bit counter cnt of width clog2(WIDTH), and last_served (1 bit).
REQ-016 In IDLE: busy=0, sout_valid=0, sout=0.
REQ-017 In IDLE, if req0 or req1 is high at a rising edge: shreg<=selected din, owner<=selected index, cnt<=0, the selected gnt pulses high for the next cycle, and state<=SHIFT.
REQ-018 Arbitration when only one req is high: grant that requester.
REQ-019 Arbitration when both reqs are high: round-robin; grant the index != last_served.
REQ-020 last_served<=owner on the edge that leaves SHIFT.
REQ-021 In SHIFT: sout=shreg[WIDTH-1], sout_valid=1, busy=1.
REQ-022 Each SHIFT edge: shreg<=shreg<<1 with zero fill, and cnt<=cnt+1.
REQ-023 At the SHIFT edge where cnt==WIDTH-1: state<=IDLE, done pulses high for the next cycle, and cnt<=0.
REQ-024 Latency, with the request sampled at edge k:
  - gnt and first bit valid in cycle k+1.
  - bits occupy cycles k+1..k+WIDTH.
  - done and IDLE in cycle k+WIDTH+1.
REQ-025 Back-to-back words have exactly one idle cycle between them: the done cycle is the IDLE cycle in which the next request is sampled.
REQ-026 Requests are ignored during SHIFT; din changes during SHIFT have no effect on the word in flight.
REQ-027 A req deasserted before its grant edge is never granted; no state change results.
REQ-028 gnt0 and gnt1 are never high in the same cycle; gnt and done are never high in the same cycle.

Reset
REQ-029 When rst is high at a rising edge, in any state including mid-SHIFT, the next cycle has:
  - state=IDLE, shreg=0, cnt=0, owner=0, last_served=1.
  - gnt0=gnt1=sout=sout_valid=busy=done=0.
REQ-030 rst has priority over a simultaneous request; no grant is issued on a reset edge.
REQ-031 The partially shifted word is discarded on reset and is not re-sent.

Verification
REQ-032 Single word: req0=1, din0=4'hC, WIDTH=4 -> gnt0 pulse; sout=1,1,0,0 with sout_valid high for 4 cycles; owner=0; done 1 cycle later.
REQ-033 Contention from reset: req0 and req1 both high, din0=4'hF, din1=4'h5 -> req0 wins (last_served=1 after reset); sout 1,1,1,1; done; then gnt1 and sout 0,1,0,1.
REQ-034 Fairness: both reqs held high for 4 words -> grants alternate 0,1,0,1; each new grant occurs exactly one cycle after the previous done.
REQ-035 Reset mid-word: req1=1, din1=4'h7; assert rst during the 2nd bit -> next cycle all outputs 0 and busy=0; a following req0 with din0=4'h1 is granted and sout=0,0,0,1.
REQ-036 Dropped request and ignored input: req0 pulses low before any grant edge -> no gnt0 and busy stays 0; changing din1 during SHIFT of 4'h5 -> sout still 0,1,0,1.
